// File: rtl/accumulator_alu.sv
// SAP-1 accumulator with add/subtract ALU, registered C/Z/N/V flags and W-bus drive.
// Optional build macro: ACC_SAT_EN (saturating result instead of modular wrap).
module accumulator_alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             La,
   input  logic             Lacc,
   input  logic             Su,
   input  logic             Lf,
   input  logic             Ea,
   input  logic             Eu,
   input  logic [WIDTH-1:0] busIn,
   input  logic [WIDTH-1:0] bIn,
   output logic [WIDTH-1:0] busOut,
   output logic             busEn,
   output logic [WIDTH-1:0] aOut,
   output logic [3:0]       flags,
   output logic             busErr
);

   logic [WIDTH-1:0] a_q, a_d;
   logic [3:0]       flags_q, flags_d;
   logic             bus_err_q, bus_err_d;

   logic [WIDTH:0]   b_ext_s;
   logic [WIDTH:0]   raw_s;
   logic [WIDTH-1:0] res_s;
   logic             carry_s;
   logic             ovf_s;
   logic             zero_s;
   logic             neg_s;

   // Raw two's-complement add/subtract; C and V always come from the unsaturated sum.
   always_comb begin
      b_ext_s = {1'b0, bIn};
      if (Su) begin
         b_ext_s = {1'b0, ~bIn} + {{WIDTH{1'b0}}, 1'b1};
      end else begin
         b_ext_s = {1'b0, bIn};
      end
      raw_s   = {1'b0, a_q} + b_ext_s;
      carry_s = raw_s[WIDTH];
      if (Su) begin
         ovf_s = (a_q[WIDTH-1] != bIn[WIDTH-1]) && (raw_s[WIDTH-1] != a_q[WIDTH-1]);
      end else begin
         ovf_s = (a_q[WIDTH-1] == bIn[WIDTH-1]) && (raw_s[WIDTH-1] != a_q[WIDTH-1]);
      end
   end

`ifdef ACC_SAT_EN
   // Clamp on unsigned carry (add) or borrow (subtract, C=0).
   always_comb begin
      res_s = raw_s[WIDTH-1:0];
      if (!Su && carry_s) begin
         res_s = {WIDTH{1'b1}};
      end else if (Su && !carry_s) begin
         res_s = {WIDTH{1'b0}};
      end else begin
         res_s = raw_s[WIDTH-1:0];
      end
   end
`else
   assign res_s = raw_s[WIDTH-1:0];
`endif

   assign zero_s = (res_s == {WIDTH{1'b0}});
   assign neg_s  = res_s[WIDTH-1];

   always_comb begin
      busOut = {WIDTH{1'b0}};
      if (Ea) begin
         busOut = a_q;
      end else if (Eu) begin
         busOut = res_s;
      end else begin
         busOut = {WIDTH{1'b0}};
      end
      busEn = Ea | Eu;
   end

   // Next state: flags always sample the pre-edge A, even when A is reloaded on the same edge.
   always_comb begin
      a_d       = a_q;
      flags_d   = flags_q;
      bus_err_d = bus_err_q;
      if (La) begin
         a_d = busIn;
      end else if (Lacc) begin
         a_d = res_s;
      end else begin
         a_d = a_q;
      end
      if (Lf) begin
         flags_d = {carry_s, zero_s, neg_s, ovf_s};
      end else begin
         flags_d = flags_q;
      end
      if (Ea && Eu) begin
         bus_err_d = 1'b1;
      end else begin
         bus_err_d = bus_err_q;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         a_q       <= {WIDTH{1'b0}};
         flags_q   <= 4'b0000;
         bus_err_q <= 1'b0;
      end else begin
         a_q       <= a_d;
         flags_q   <= flags_d;
         bus_err_q <= bus_err_d;
      end
   end

   assign aOut   = a_q;
   assign flags  = flags_q;
   assign busErr = bus_err_q;

endmodule
